// File: rtl/aes_pkg.sv
// Shared definitions for the AES decryption round controller: FSM states,
// round count and round-key index width.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int KEY_IDX_W = 4;

  localparam logic [KEY_IDX_W-1:0] KEY_LAST  = KEY_IDX_W'(AES_NR);
  localparam logic [KEY_IDX_W-1:0] CNT_START = KEY_IDX_W'(AES_NR - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/aes_dec_round_ctrl.sv
// AES-128 decryption round sequencer: INIT, nine ROUNDs, FINAL, DONE; Moore outputs
// registered from next state. Optional abort input when AES_DEC_CTRL_ABORT_EN is defined.
module aes_dec_round_ctrl
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef AES_DEC_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 load_sel,
  output logic                 state_we,
  output logic [KEY_IDX_W-1:0] key_addr,
  output logic                 mix_col_en,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic [KEY_IDX_W-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = S_INIT;
          cnt_nxt   = CNT_START;
        end
      end
      S_INIT: begin
        state_nxt = S_ROUND;
        cnt_nxt   = cnt;
      end
      S_ROUND: begin
        // Last inverse round uses key 1; the counter never drops below 1 here.
        if (cnt <= KEY_IDX_W'(1)) begin
          state_nxt = S_FINAL;
        end else begin
          cnt_nxt = cnt - KEY_IDX_W'(1);
        end
      end
      S_FINAL: state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef AES_DEC_CTRL_ABORT_EN
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
`endif
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      state_we   <= 1'b0;
      load_sel   <= 1'b0;
      mix_col_en <= 1'b0;
      key_addr   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      in_ready   <= (state_nxt == S_IDLE);
      out_valid  <= (state_nxt == S_DONE);
      busy       <= (state_nxt != S_IDLE);
      state_we   <= (state_nxt == S_INIT) || (state_nxt == S_ROUND) || (state_nxt == S_FINAL);
      load_sel   <= (state_nxt == S_INIT);
      mix_col_en <= (state_nxt == S_ROUND);
      case (state_nxt)
        S_INIT:  key_addr <= KEY_LAST;
        S_ROUND: key_addr <= cnt_nxt;
        default: key_addr <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Self-checking bench for aes_dec_round_ctrl against a cycle-count model of one block.
module tb_aes_dec_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       abort = 1'b0;
  logic       in_ready, out_valid, load_sel, state_we, mix_col_en, busy;
  logic [3:0] key_addr;

  int vectors = 0;
  int fails   = 0;
  int ph      = 0;  // 0 = idle, 1..11 = cycles since acceptance while processing, 12 = done

  always #5 clk = ~clk;

  aes_dec_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef AES_DEC_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .load_sel   (load_sel),
    .state_we   (state_we),
    .key_addr   (key_addr),
    .mix_col_en (mix_col_en),
    .busy       (busy)
  );

  wire [9:0] obs = {in_ready, out_valid, busy, state_we, load_sel, mix_col_en, key_addr};

  // Expected outputs as a function of cycles elapsed since the block was accepted.
  function automatic logic [9:0] exp_vec(input int p);
    logic [3:0] k;
    k = 4'd0;
    if (p == 1) k = 4'd10;
    else if (p >= 2 && p <= 10) k = 4'(11 - p);
    return {p == 0, p == 12, p != 0, (p >= 1 && p <= 11), p == 1, (p >= 2 && p <= 10), k};
  endfunction

  task automatic step(input logic iv, input logic ordy, input logic r);
    in_valid  = iv;
    out_ready = ordy;
    rst       = r;
    @(posedge clk);
    if (r) ph = 0;
`ifdef AES_DEC_CTRL_ABORT_EN
    else if (abort && ph != 0) ph = 0;
`endif
    else if (ph == 0) ph = iv ? 1 : 0;
    else if (ph < 12) ph = ph + 1;
    else if (ordy) ph = 0;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
      vectors++;
      if (obs !== 10'b10_0000_0000) begin
        fails++;
        $display("FAIL reset_hold: got %b want %b", obs, 10'b10_0000_0000);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== 10'b10_0000_0000) begin
      fails++;
      $display("FAIL reset_release: got %b want %b", obs, 10'b10_0000_0000);
    end
  endtask

  task automatic test_latency;
    int n, we_cnt, mix_cnt;
    logic [3:0] keys[$];
    step(1'b1, 1'b0, 1'b0);
    n = 1; we_cnt = 0; mix_cnt = 0;
    if (state_we) keys.push_back(key_addr);
    we_cnt += int'(state_we);
    mix_cnt += int'(mix_col_en);
    while (!out_valid && n < 30) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
      vectors++;
      if (obs !== exp_vec(ph)) begin
        fails++;
        $display("FAIL latency_cycle%0d: got %b want %b", n, obs, exp_vec(ph));
      end
      if (state_we) keys.push_back(key_addr);
      we_cnt += int'(state_we);
      mix_cnt += int'(mix_col_en);
    end
    vectors++;
    if (n != 12) begin
      fails++;
      $display("FAIL latency: out_valid after %0d cycles want 12", n);
    end
    vectors++;
    if (we_cnt != 11 || mix_cnt != 9) begin
      fails++;
      $display("FAIL we_mix_count: state_we %0d want 11, mix_col_en %0d want 9", we_cnt, mix_cnt);
    end
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (i >= keys.size() || keys[i] !== 4'(10 - i)) begin
        fails++;
        $display("FAIL key_seq[%0d]: got %0d want %0d", i, (i < keys.size()) ? keys[i] : 4'hx, 10 - i);
      end
    end
  endtask

  task automatic test_done_hold;
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(0, 1), 1'b0, 1'b0);
      vectors++;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && state_we === 1'b0)) begin
        fails++;
        $display("FAIL done_hold: ov=%b ir=%b we=%b want 1 0 0", out_valid, in_ready, state_we);
      end
    end
    step(1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs !== 10'b10_0000_0000) begin
      fails++;
      $display("FAIL done_release: got %b want %b", obs, 10'b10_0000_0000);
    end
  endtask

  task automatic test_reset_mid_round;
    int n;
    step(1'b1, 1'b0, 1'b0);
    n = 0;
    while (key_addr !== 4'd5 && n < 20) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    vectors++;
    if (key_addr !== 4'd5 || mix_col_en !== 1'b1) begin
      fails++;
      $display("FAIL reach_key5: key_addr %0d mix %b want 5 1", key_addr, mix_col_en);
    end
    step(1'b1, 1'b1, 1'b1);
    vectors++;
    if (obs !== 10'b10_0000_0000) begin
      fails++;
      $display("FAIL reset_mid_round: got %b want %b", obs, 10'b10_0000_0000);
    end
    step(1'b1, 1'b0, 1'b0);
    n = 1;
    while (!out_valid && n < 30) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    vectors++;
    if (n != 12) begin
      fails++;
      $display("FAIL post_reset_latency: %0d cycles want 12", n);
    end
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_in_valid_ignored;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step((i == 4 || i == 5), 1'b1, 1'b0);
      vectors++;
      if (obs !== exp_vec(ph)) begin
        fails++;
        $display("FAIL ignore_in_valid_cycle%0d: got %b want %b", i, obs, exp_vec(ph));
      end
    end
  endtask

`ifdef AES_DEC_CTRL_ABORT_EN
  task automatic test_abort;
    int n;
    logic seen_ov;
    step(1'b1, 1'b0, 1'b0);
    n = 0;
    while (key_addr !== 4'd3 && n < 20) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    abort = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    vectors++;
    if (obs !== 10'b10_0000_0000) begin
      fails++;
      $display("FAIL abort: got %b want %b", obs, 10'b10_0000_0000);
    end
    seen_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      seen_ov |= out_valid;
    end
    vectors++;
    if (seen_ov !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_out_valid: out_valid seen %b want 0", seen_ov);
    end
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
`ifdef AES_DEC_CTRL_ABORT_EN
      abort = ($urandom_range(0, 39) == 0);
`endif
      step($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
      vectors++;
      if (obs !== exp_vec(ph)) begin
        fails++;
        $display("FAIL random_cycle%0d: got %b want %b (phase %0d)", i, obs, exp_vec(ph), ph);
      end
    end
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_done_hold();
    test_reset_mid_round();
    test_in_valid_ignored();
`ifdef AES_DEC_CTRL_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_ctrl.md
AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  ciphertext block and key schedule available.
REQ-005 in_ready  output  1  controller accepts a new block.
REQ-006 out_valid  output  1  plaintext in datapath state register is final.
REQ-007 out_ready  input  1  consumer takes the plaintext.
REQ-008 load_sel  output  1  1 = state register loads the input block XOR key; 0 = loads round feedback.
REQ-009 state_we  output  1  datapath state register write enable.
REQ-010 key_addr  output  4  round-key index into the key store (0..10).
REQ-011 mix_col_en  output  1  drives the inverse-MixColumns enable; 0 = bypass.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM IDLE -> INIT -> ROUND -> FINAL -> DONE -> IDLE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready go to INIT; otherwise stay.
REQ-015 INIT, one cycle: load_sel=1, state_we=1, key_addr=10, mix_col_en=0; round counter set to 9.
REQ-016 ROUND, nine cycles: state_we=1, load_sel=0, mix_col_en=1, key_addr=round counter; counter decrements 9..1; leave for FINAL when counter==1.
REQ-017 FINAL, one cycle: state_we=1, load_sel=0, mix_col_en=0, key_addr=0.
REQ-018 DONE: out_valid=1, state_we=0; hold until out_ready=1, then go to IDLE.
REQ-019 Latency: out_valid rises exactly 12 cycles after the accepting edge; it stays high while out_ready=0.
REQ-020 in_ready=0 in all states except IDLE; in_valid outside IDLE is ignored; no block overlap.
REQ-021 out_ready outside DONE has no effect.
REQ-022 Outputs SHALL be Moore, decoded only from the state and counter registers, with no combinational input-to-output path.
REQ-023 The round counter is 4 bits unsigned, never wraps below 1 in ROUND, and is 0 outside INIT/ROUND.
REQ-024 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-025 rst=1 at any edge, including mid-ROUND or in DONE, forces IDLE and clears the counter.
REQ-026 Values while in reset and on the first cycle after it: in_ready=1, out_valid=0, busy=0, state_we=0, load_sel=0, mix_col_en=0, key_addr=0.
REQ-027 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 With AES_DEC_CTRL_ABORT_EN defined, add input abort (1 bit): abort=1 in INIT/ROUND/FINAL/DONE returns to IDLE on the next edge with state_we=0 in that cycle; abort in IDLE is ignored.
REQ-029 Without AES_DEC_CTRL_ABORT_EN, the abort port and its logic are absent, and behaviour is otherwise identical.

Structure
REQ-030 The state enum, AES_NR=10 and the 4-bit key-index width SHALL live in shared package aes_pkg.
REQ-031 The block is a single module with no sub-module; the round datapath (including the inverse-MixColumns stage) stays outside and is driven only through these outputs.

Verification
REQ-032 Reset, then in_valid=1 at cycle 0 -> INIT at cycle 1, out_valid=1 at cycle 12, key_addr sequence 10,9,8..1,0.
REQ-033 Same run -> mix_col_en=1 for exactly the 9 ROUND cycles, 0 in INIT and FINAL; state_we high for exactly 11 cycles.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, in_ready=0, state_we=0; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst at ROUND with key_addr=5 -> next cycle all outputs at reset values; a new block then completes in 12 cycles.
REQ-036 Pulse in_valid during ROUND -> ignored; counter and key_addr sequence undisturbed.
REQ-037 With AES_DEC_CTRL_ABORT_EN, abort at key_addr=3 -> IDLE next edge, out_valid never asserted; without the macro, the build has no abort port.
